// File: rtl/stage_mem_pkg.sv
// Shared size codes and FSM state type for the MEM stage.
package stage_mem_pkg;

   localparam logic [2:0] LD_W  = 3'b000;
   localparam logic [2:0] LD_H  = 3'b001;
   localparam logic [2:0] LD_HU = 3'b010;
   localparam logic [2:0] LD_B  = 3'b011;
   localparam logic [2:0] LD_BU = 3'b100;

   localparam logic [1:0] ST_W  = 2'b00;
   localparam logic [1:0] ST_H  = 2'b01;
   localparam logic [1:0] ST_B  = 2'b10;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} memState_t;

endpackage

// File: rtl/stage_mem_if.sv
// Data-memory req/ack bus between the MEM stage (master) and memory (slave).
interface stage_mem_if;
   logic        memReq;
   logic        memWe;
   logic [31:0] memAddr;
   logic [3:0]  memBe;
   logic [31:0] memWdata;
   logic [31:0] memRdata;
   logic        memAck;

   modport master (output memReq, memWe, memAddr, memBe, memWdata,
                   input  memRdata, memAck);
   modport slave  (input  memReq, memWe, memAddr, memBe, memWdata,
                   output memRdata, memAck);
endinterface

// File: rtl/stage_mem_lane_align.sv
// Combinational lane logic: store byte enables/placement, load extraction, alignment check.
module mem_lane_align
   import stage_mem_pkg::*;
(
   input  logic [2:0]  loadSize,
   input  logic [1:0]  storeSize,
   input  logic        isWrite,
   input  logic [1:0]  addrLo,
   input  logic [31:0] rt,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] loadData,
   output logic        misaligned
);

   logic [7:0]  byteSel;
   logic [15:0] halfSel;

   assign byteSel = rdata[{addrLo, 3'b000} +: 8];
   assign halfSel = addrLo[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      be         = 4'b1111;
      wdata      = rt;
      loadData   = rdata;
      misaligned = 1'b0;
      if (isWrite) begin
         case (storeSize)
            ST_B: begin
               be    = 4'b0001 << addrLo;
               wdata = {4{rt[7:0]}};
            end
            ST_H: begin
               be         = 4'b0011 << addrLo;
               wdata      = {2{rt[15:0]}};
               misaligned = addrLo[0];
            end
            ST_W:    misaligned = |addrLo;
            default: misaligned = 1'b1;
         endcase
      end else begin
         // Unknown load codes fall through to word behaviour.
         case (loadSize)
            LD_B:  loadData = {{24{byteSel[7]}}, byteSel};
            LD_BU: loadData = {24'd0, byteSel};
            LD_H: begin
               loadData   = {{16{halfSel[15]}}, halfSel};
               misaligned = addrLo[0];
            end
            LD_HU: begin
               loadData   = {16'd0, halfSel};
               misaligned = addrLo[0];
            end
            default: misaligned = |addrLo;
         endcase
      end
   end

endmodule

// File: rtl/stage_mem.sv
// MEM pipeline stage: req/ack data bus, lane handling, stall and MEM/WB latch.
// Optional bus timeout abort enabled by defining MEM_TIMEOUT_EN.
module stage_mem
   import stage_mem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic        RegWrite,
   input  logic [1:0]  MemtoReg,
   input  logic [31:0] inAlu,
   input  logic [31:0] inDataRt,
   input  logic [4:0]  inMuxRtRd,
   input  logic [2:0]  inflagLoadWordDividerMEM,
   input  logic [1:0]  inflagStoreWordDividerMEM,
   stage_mem_if.master bus,
   output logic        stallMem,
   output logic        misalign,
   output logic        outRegWrite,
   output logic [1:0]  outMemtoReg,
   output logic [31:0] outMemData,
   output logic [31:0] outAlu,
   output logic [4:0]  outMuxRtRd
);

   memState_t   state;
   logic        access, isWrite, misAl, keepWb;
   logic [3:0]  laneBe;
   logic [31:0] laneWdata, loadData, capData;

   assign access  = MemRead | MemWrite;
   assign isWrite = MemWrite & ~MemRead;

   mem_lane_align uAlign (
      .loadSize   (inflagLoadWordDividerMEM),
      .storeSize  (inflagStoreWordDividerMEM),
      .isWrite    (isWrite),
      .addrLo     (inAlu[1:0]),
      .rt         (inDataRt),
      .rdata      (bus.memRdata),
      .be         (laneBe),
      .wdata      (laneWdata),
      .loadData   (loadData),
      .misaligned (misAl)
   );

   // Stall is raised in the presentation cycle so EX/MEM holds the access operands.
   assign stallMem = rst_n & (((state == IDLE) & access & ~misAl) | (state == WAIT));

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0] waitCnt;
   logic             abortAcc;
   assign keepWb = ~abortAcc;
`else
   assign keepWb = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         bus.memReq   <= 1'b0;
         bus.memWe    <= 1'b0;
         bus.memAddr  <= '0;
         bus.memBe    <= '0;
         bus.memWdata <= '0;
         misalign     <= 1'b0;
         capData      <= '0;
         outRegWrite  <= 1'b0;
         outMemtoReg  <= '0;
         outMemData   <= '0;
         outAlu       <= '0;
         outMuxRtRd   <= '0;
`ifdef MEM_TIMEOUT_EN
         waitCnt      <= '0;
         abortAcc     <= 1'b0;
`endif
      end else begin
         misalign <= 1'b0;
         case (state)
            IDLE: begin
               if (access && !misAl) begin
                  state        <= WAIT;
                  bus.memReq   <= 1'b1;
                  bus.memWe    <= isWrite;
                  bus.memAddr  <= {inAlu[31:2], 2'b00};
                  bus.memBe    <= laneBe;
                  bus.memWdata <= isWrite ? laneWdata : 32'd0;
                  outRegWrite  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
                  waitCnt      <= '0;
                  abortAcc     <= 1'b0;
`endif
               end else begin
                  // Non-access passes straight through; a misaligned access retires as a no-write.
                  misalign    <= access;
                  outRegWrite <= RegWrite & ~access;
                  outMemtoReg <= MemtoReg;
                  outMemData  <= 32'd0;
                  outAlu      <= inAlu;
                  outMuxRtRd  <= inMuxRtRd;
               end
            end
            WAIT: begin
               outRegWrite <= 1'b0;
               if (bus.memAck) begin
                  bus.memReq <= 1'b0;
                  bus.memWe  <= 1'b0;
                  capData    <= isWrite ? 32'd0 : loadData;
                  state      <= DONE;
               end
`ifdef MEM_TIMEOUT_EN
               else if (waitCnt == CNT_LAST) begin
                  bus.memReq <= 1'b0;
                  bus.memWe  <= 1'b0;
                  capData    <= 32'd0;
                  abortAcc   <= 1'b1;
                  misalign   <= 1'b1;
                  state      <= DONE;
               end else begin
                  waitCnt <= waitCnt + 1'b1;
               end
`endif
            end
            DONE: begin
               outRegWrite <= RegWrite & keepWb;
               outMemtoReg <= MemtoReg;
               outMemData  <= capData;
               outAlu      <= inAlu;
               outMuxRtRd  <= inMuxRtRd;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stage_mem.sv
// Self-checking bench for stage_mem: directed plan cases plus randomized accesses vs a reference model.
module tb_stage_mem;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        MemRead = 0, MemWrite = 0, RegWrite = 0;
   logic [1:0]  MemtoReg = 0;
   logic [31:0] inAlu = 0, inDataRt = 0;
   logic [4:0]  inMuxRtRd = 0;
   logic [2:0]  inflagLoadWordDividerMEM = 0;
   logic [1:0]  inflagStoreWordDividerMEM = 0;
   logic        stallMem, misalign, outRegWrite;
   logic [1:0]  outMemtoReg;
   logic [31:0] outMemData, outAlu;
   logic [4:0]  outMuxRtRd;

   int errors = 0;
   int checks = 0;

   stage_mem_if bus ();

   stage_mem #(.TIMEOUT_CYCLES(4)) dut (
      .clk                       (clk),
      .rst_n                     (rst_n),
      .MemRead                   (MemRead),
      .MemWrite                  (MemWrite),
      .RegWrite                  (RegWrite),
      .MemtoReg                  (MemtoReg),
      .inAlu                     (inAlu),
      .inDataRt                  (inDataRt),
      .inMuxRtRd                 (inMuxRtRd),
      .inflagLoadWordDividerMEM  (inflagLoadWordDividerMEM),
      .inflagStoreWordDividerMEM (inflagStoreWordDividerMEM),
      .bus                       (bus.master),
      .stallMem                  (stallMem),
      .misalign                  (misalign),
      .outRegWrite               (outRegWrite),
      .outMemtoReg               (outMemtoReg),
      .outMemData                (outMemData),
      .outAlu                    (outAlu),
      .outMuxRtRd                (outMuxRtRd)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   // Reference model, written from the access rules rather than lane hardware.
   function automatic bit mdlMis(bit rd, bit wr, logic [2:0] ls, logic [1:0] ss, int a);
      if (rd) begin
         if (ls == 3'd1 || ls == 3'd2) return (a % 2) != 0;
         if (ls == 3'd3 || ls == 3'd4) return 0;
         return a != 0;
      end
      if (wr) begin
         if (ss == 2'd3) return 1;
         if (ss == 2'd1) return (a % 2) != 0;
         if (ss == 2'd2) return 0;
         return a != 0;
      end
      return 0;
   endfunction

   function automatic logic [31:0] mdlBe(bit rd, logic [1:0] ss, int a);
      if (rd) return 32'hF;
      if (ss == 2'd2) return 32'd1 << a;
      if (ss == 2'd1) return 32'd3 << a;
      return 32'hF;
   endfunction

   function automatic logic [31:0] mdlWdata(logic [1:0] ss, logic [31:0] rt);
      if (ss == 2'd2) return (rt & 32'hFF) * 32'h01010101;
      if (ss == 2'd1) return (rt & 32'hFFFF) * 32'h00010001;
      return rt;
   endfunction

   function automatic logic [31:0] mdlLoad(logic [2:0] ls, int a, logic [31:0] rdata);
      logic [31:0] v;
      if (ls == 3'd3 || ls == 3'd4) begin
         v = (rdata >> (8 * a)) & 32'hFF;
         if (ls == 3'd3 && v >= 32'd128) v = v + 32'hFFFFFF00;
         return v;
      end
      if (ls == 3'd1 || ls == 3'd2) begin
         v = (rdata >> (16 * (a / 2))) & 32'hFFFF;
         if (ls == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF0000;
         return v;
      end
      return rdata;
   endfunction

   task automatic setNop();
      MemRead = 0; MemWrite = 0; RegWrite = 0;
   endtask

   // Called at posedge+1 in IDLE; returns at posedge+1 back in IDLE.
   task automatic doAccess(input bit rd, input bit wr, input bit rw, input logic [2:0] ls,
                           input logic [1:0] ss, input logic [1:0] mtr, input logic [31:0] addr,
                           input logic [31:0] rt, input logic [31:0] rdata, input logic [4:0] rdst,
                           input int ackDelay, output logic [31:0] oData, output logic [31:0] oBe,
                           output logic [31:0] oWdata, output logic [31:0] oAddr,
                           output int stallCnt);
      int a;
      bit mis, stable;
      logic [31:0] sAddr, sWdata;
      logic [3:0] sBe;
      logic sWe;
      a = int'(addr % 4);
      mis = mdlMis(rd, wr, ls, ss, a);
      MemRead = rd; MemWrite = wr; RegWrite = rw; MemtoReg = mtr;
      inAlu = addr; inDataRt = rt; inMuxRtRd = rdst;
      inflagLoadWordDividerMEM = ls; inflagStoreWordDividerMEM = ss;
      oData = 0; oBe = 0; oWdata = 0; oAddr = 0; stallCnt = 0;
      @(negedge clk);
      if (stallMem) stallCnt++;
      if (!(rd || wr)) begin
         chk("nop_stall", stallMem, 0);
         @(posedge clk); #1;
         chk("nop_rw", outRegWrite, rw);
         chk("nop_alu", outAlu, addr);
         chk("nop_rd", outMuxRtRd, rdst);
         chk("nop_mtr", outMemtoReg, mtr);
         chk("nop_data", outMemData, 0);
         oData = outMemData;
      end else if (mis) begin
         chk("mis_stall", stallMem, 0);
         @(posedge clk); #1;
         chk("mis_pulse", misalign, 1);
         chk("mis_req", bus.memReq, 0);
         chk("mis_rw", outRegWrite, 0);
         chk("mis_alu", outAlu, addr);
         setNop();
         @(posedge clk); #1;
         chk("mis_pulse_end", misalign, 0);
      end else begin
         chk("acc_stall0", stallMem, 1);
         @(posedge clk); #1;
         chk("acc_req", bus.memReq, 1);
         chk("acc_we", bus.memWe, wr && !rd);
         chk("acc_addr", bus.memAddr, addr & 32'hFFFFFFFC);
         chk("acc_be", bus.memBe, mdlBe(rd, ss, a));
         if (wr && !rd) chk("acc_wdata", bus.memWdata, mdlWdata(ss, rt));
         chk("acc_bubble", outRegWrite, 0);
         oBe = bus.memBe; oWdata = bus.memWdata; oAddr = bus.memAddr;
         sAddr = bus.memAddr; sBe = bus.memBe; sWe = bus.memWe; sWdata = bus.memWdata;
         stable = 1;
         for (int k = 0; k <= ackDelay; k++) begin
            if (k == ackDelay) begin bus.memAck = 1; bus.memRdata = rdata; end
            else bus.memRdata = $urandom;
            @(negedge clk);
            if (stallMem) stallCnt++;
            if (!bus.memReq || bus.memAddr !== sAddr || bus.memBe !== sBe ||
                bus.memWe !== sWe || bus.memWdata !== sWdata) stable = 0;
            @(posedge clk); #1;
            bus.memAck = 0;
         end
         chk("acc_stable", stable, 1);
         chk("done_req", bus.memReq, 0);
         chk("done_mis", misalign, 0);
         @(negedge clk);
         if (stallMem) stallCnt++;
         chk("done_stall", stallMem, 0);
         @(posedge clk); #1;
         chk("wb_rw", outRegWrite, rw);
         chk("wb_alu", outAlu, addr);
         chk("wb_rd", outMuxRtRd, rdst);
         chk("wb_mtr", outMemtoReg, mtr);
         if (rd) chk("wb_data", outMemData, mdlLoad(ls, a, rdata));
         chk("stall_cycles", stallCnt, 2 + ackDelay);
         oData = outMemData;
         setNop();
      end
   endtask

   initial begin
      logic [31:0] d, be, wd, ad;
      int sc;
      bit rd, wr;
      bus.memAck = 0;
      bus.memRdata = 0;

      // Reset state
      #12;
      chk("rst_req", bus.memReq, 0);
      chk("rst_we", bus.memWe, 0);
      chk("rst_addr", bus.memAddr, 0);
      chk("rst_be", bus.memBe, 0);
      chk("rst_wdata", bus.memWdata, 0);
      chk("rst_stall", stallMem, 0);
      chk("rst_mis", misalign, 0);
      chk("rst_wb", {outRegWrite, outMemtoReg, outMuxRtRd}, 0);
      chk("rst_wbdata", outMemData, 0);
      chk("rst_wbalu", outAlu, 0);
      @(posedge clk); #1;
      rst_n = 1;
      @(posedge clk); #1;

      // SB at 0x103
      doAccess(0, 1, 0, 3'd0, 2'd2, 2'd0, 32'h103, 32'hAABBCCDD, 0, 5'd3, 0, d, be, wd, ad, sc);
      chk("sb_addr", ad, 32'h100);
      chk("sb_be", be, 32'h8);
      chk("sb_wdata", wd, 32'hDDDDDDDD);
      chk("sb_stall", sc, 2);
      chk("sb_rw", outRegWrite, 0);

      // LBU / LB at 0x101
      doAccess(1, 0, 1, 3'd4, 2'd0, 2'd1, 32'h101, 0, 32'h12348056, 5'd4, 0, d, be, wd, ad, sc);
      chk("lbu_data", d, 32'h00000080);
      doAccess(1, 0, 1, 3'd3, 2'd0, 2'd1, 32'h101, 0, 32'h12348056, 5'd5, 0, d, be, wd, ad, sc);
      chk("lb_data", d, 32'hFFFFFF80);
      chk("lb_rw", outRegWrite, 1);

      // LH / LHU at 0x102
      doAccess(1, 0, 1, 3'd1, 2'd0, 2'd1, 32'h102, 0, 32'hF00D1234, 5'd6, 1, d, be, wd, ad, sc);
      chk("lh_data", d, 32'hFFFFF00D);
      doAccess(1, 0, 1, 3'd2, 2'd0, 2'd1, 32'h102, 0, 32'hF00D1234, 5'd7, 2, d, be, wd, ad, sc);
      chk("lhu_data", d, 32'h0000F00D);

      // Misaligned LW
      doAccess(1, 0, 1, 3'd0, 2'd0, 2'd1, 32'h102, 0, 0, 5'd8, 0, d, be, wd, ad, sc);

      // LW, ack after a long wait
      doAccess(1, 0, 1, 3'd0, 2'd0, 2'd1, 32'h204, 0, 32'hCAFEBABE, 5'd9, 4, d, be, wd, ad, sc);
      chk("lw_slow_stall", sc, 6);
      chk("lw_slow_data", d, 32'hCAFEBABE);

      // Stray ack in IDLE
      bus.memAck = 1;
      @(negedge clk);
      chk("stray_stall", stallMem, 0);
      @(posedge clk); #1;
      bus.memAck = 0;
      chk("stray_req", bus.memReq, 0);
      doAccess(1, 0, 1, 3'd0, 2'd0, 2'd0, 32'h300, 0, 32'h13572468, 5'd10, 0, d, be, wd, ad, sc);

      // Reset asserted mid-WAIT
      MemRead = 1; RegWrite = 1; inAlu = 32'h400; inflagLoadWordDividerMEM = 3'd0;
      @(posedge clk); #1;
      chk("mid_req_before", bus.memReq, 1);
      #2 rst_n = 0;
      #1;
      chk("mid_req_async", bus.memReq, 0);
      chk("mid_stall", stallMem, 0);
      setNop();
      @(posedge clk); #1;
      rst_n = 1;
      doAccess(1, 0, 1, 3'd4, 2'd0, 2'd2, 32'h503, 0, 32'h9A000000, 5'd11, 0, d, be, wd, ad, sc);
      chk("post_rst_data", d, 32'h9A);

`ifdef MEM_TIMEOUT_EN
      // No ack: aborted after four WAIT cycles
      MemRead = 1; RegWrite = 1; inAlu = 32'h600; inflagLoadWordDividerMEM = 3'd0;
      sc = 0;
      @(negedge clk); if (stallMem) sc++;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         @(negedge clk); if (stallMem) sc++;
      end
      @(posedge clk); #1;
      chk("to_req", bus.memReq, 0);
      chk("to_pulse", misalign, 1);
      chk("to_stall", stallMem, 0);
      chk("to_stall_cycles", sc, 5);
      @(posedge clk); #1;
      chk("to_rw", outRegWrite, 0);
      chk("to_pulse_end", misalign, 0);
      setNop();
`endif

      // Randomized traffic
      for (int n = 0; n < 60; n++) begin
         int kind;
         kind = int'($urandom_range(0, 3));
         rd = (kind == 1 || kind == 3);
         wr = (kind == 2 || kind == 3);
         doAccess(rd, wr, 1'($urandom), 3'($urandom), 2'($urandom), 2'($urandom),
                  $urandom, $urandom, $urandom, 5'($urandom), int'($urandom_range(0, 3)),
                  d, be, wd, ad, sc);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
